stdcore_rf_fifo_ctl: RTL and testbench
======================================

STDCORE_RF_FIFO_CTL -- requirements
Module: stdcore_rf_fifo_ctl

Interface
REQ-001 SHALL have parameter DW, default 8: data width in bits.
REQ-002 SHALL have parameter DEPTH, default 16: memory entries; any value >= 2, need not be a power of two.
REQ-003 SHALL have parameter AW, default 4: memory address width, >= ceil(log2(DEPTH)).
REQ-004 SHALL have parameter LW, default 5: level width, >= ceil(log2(DEPTH+2)).
REQ-005 SHALL have parameter AF_LVL, default 12: almost-full threshold.
REQ-006 SHALL have port clk, input, 1: the only clock. Every port below is synchronous to clk.
REQ-007 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-008 SHALL have port flush, input, 1: synchronous clear of all contents.
REQ-009 SHALL have port in_valid, input, 1: push request.
REQ-010 SHALL have port in_data, input, DW: push data.
REQ-011 SHALL have port in_ready, output, 1: push accepted this cycle if in_valid is also 1.
REQ-012 SHALL have port out_valid, output, 1: out_data holds the head entry.
REQ-013 SHALL have port out_data, output, DW: head entry, driven directly from mem_rdata.
REQ-014 SHALL have port out_ready, input, 1: pop request.
REQ-015 SHALL have port level, output, LW: total entries held.
REQ-016 SHALL have port afull, output, 1: level >= AF_LVL.
REQ-017 SHALL have port mem_we_n, output, 1: write enable to the external two-port RF memory, active low.
REQ-018 SHALL have port mem_waddr, output, AW: memory write address.
REQ-019 SHALL have port mem_wdata, output, DW: memory write data.
REQ-020 SHALL have port mem_re_n, output, 1: read enable to the memory, active low.
REQ-021 SHALL have port mem_raddr, output, AW: memory read address.
REQ-022 SHALL have port mem_rdata, input, DW: memory read data; 1-cycle latency, held until the next read.

Function
REQ-023 SHALL keep the following state: wptr and rptr (0..DEPTH-1), mcnt (unread memory entries, 0..DEPTH) and head (output stage flag).
REQ-024 SHALL drive in_ready = (mcnt < DEPTH) & ~flush.
REQ-025 SHALL treat a push as in_valid & in_ready.
REQ-026 On a push, SHALL drive mem_we_n=0, mem_waddr=wptr and mem_wdata=in_data in the same cycle, and advance wptr.
REQ-027 SHALL treat a pop as out_valid & out_ready.
REQ-028 SHALL drive out_valid = head.
REQ-029 SHALL issue a prefetch read (mem_re_n=0, mem_raddr=rptr) when mcnt > 0 & (~head | pop) & ~flush, and advance rptr on that read.
REQ-030 SHALL set head=1 at the next edge after any prefetch read.
REQ-031 SHALL clear head at the next edge after a pop with no prefetch read.
REQ-032 SHALL update mcnt by +push -read each cycle; a push and a read in the same cycle leave mcnt unchanged.
REQ-033 SHALL wrap wptr and rptr from DEPTH-1 to 0.
REQ-034 SHALL give a total capacity of DEPTH+1: DEPTH in memory plus one in the held read register.
REQ-035 SHALL drive level = mcnt + head, registered consistently with mcnt and head.
REQ-036 SHALL give an empty-to-valid latency of 2 cycles: push at edge E0, read issued in the following cycle, out_valid=1 after E1.
REQ-037 SHALL give a sustained throughput of one push and one pop per cycle when 0 < mcnt < DEPTH.
REQ-038 SHALL never assert mem_we_n=0 and mem_re_n=0 in the same cycle with mem_waddr == mem_raddr; a read addresses only written, unread slots.
REQ-039 SHALL keep out_data stable while out_valid=1 and out_ready=0, since no read is issued.
REQ-040 When flush=1, at the next edge SHALL set wptr=rptr=0, mcnt=0 and head=0.
REQ-041 When flush=1, SHALL ignore any in_valid and out_ready in that cycle and issue no memory access.
REQ-042 SHALL ignore a push while full (mcnt == DEPTH): no write, no state change.
REQ-043 SHALL ignore a pop while empty: no state change.
REQ-044 SHALL hold mem_waddr, mem_wdata and mem_raddr at their last values when the corresponding enable is high.

Reset
REQ-045 On rst_n=0, SHALL immediately and asynchronously set wptr=0, rptr=0, mcnt=0 and head=0.
REQ-046 During reset, outputs SHALL be: in_ready=1 (once flush=0), out_valid=0, level=0, afull=0, mem_we_n=1, mem_re_n=1, mem_waddr=0 and mem_raddr=0.
REQ-047 Reset mid-operation SHALL discard all contents; memory contents are don't-care and are never read back without a fresh push.

Verification
REQ-048 The bench SHALL cover first-word latency, DEPTH=4: push 0xA5 at edge 0 with out_ready=0 -> mem_re_n=0 in cycle 1 with mem_raddr=0; out_valid=1 and out_data=0xA5 from edge 2; level=1.
REQ-049 The bench SHALL cover fill to capacity, DEPTH=4: 6 pushes of 1..6 with out_ready=0 -> first 5 accepted, in_ready=0 on the 6th, level=5, afull per AF_LVL; then pop all -> order 1..5, level returns to 0.
REQ-050 The bench SHALL cover streaming with wrap, DEPTH=3: 20 consecutive push+pop cycles of values 0..19 -> output in order, no lost or duplicated data, no address-conflict cycle, pointers wrap 2->0.
REQ-051 The bench SHALL cover backpressure stall: out_valid=1 and out_ready=0 for 5 cycles while pushing -> out_data constant, mem_re_n=1 throughout.
REQ-052 The bench SHALL cover flush with simultaneous push and pop at level=3 -> next cycle level=0 and out_valid=0; the pushed word is not stored.
REQ-053 The bench SHALL cover asynchronous reset asserted between edges at level=4 -> out_valid=0 and level=0 immediately; after release, push 0x11 -> 0x11 appears after 2 cycles.

Source files
------------

// File: rtl/stdcore_rf_fifo_ctl.sv
// FIFO controller for an external two-port register-file memory. A one-word
// read-data holding stage sits behind the memory, so capacity is DEPTH+1 words.
module stdcore_rf_fifo_ctl #(
    parameter int DW     = 8,
    parameter int DEPTH  = 16,
    parameter int AW     = 4,
    parameter int LW     = 5,
    parameter int AF_LVL = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic [LW-1:0] level,
    output logic          afull,
    output logic          mem_we_n,
    output logic [AW-1:0] mem_waddr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_re_n,
    output logic [AW-1:0] mem_raddr,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [AW-1:0] LAST_PTR  = AW'(DEPTH - 1);
    localparam logic [LW-1:0] DEPTH_CNT = LW'(DEPTH);

    logic [AW-1:0] wptr_r, rptr_r, waddr_hold_r, raddr_hold_r;
    logic [DW-1:0] wdata_hold_r;
    logic [LW-1:0] mcnt_r, level_r;
    logic          head_r, afull_r;

    logic          push_s, pop_s, rd_s, head_nxt_s, afull_nxt_s;
    logic [AW-1:0] wptr_nxt_s, rptr_nxt_s;
    logic [LW-1:0] mcnt_nxt_s, level_nxt_s;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        logic [AW-1:0] r;
        if (p == LAST_PTR) begin
            r = {AW{1'b0}};
        end else begin
            r = p + AW'(1'b1);
        end
        return r;
    endfunction

    // A read is only issued when memory holds an unread word, so it never
    // targets the slot being written (a full memory refuses the push).
    assign in_ready = (mcnt_r < DEPTH_CNT) & ~flush;
    assign push_s   = in_valid & in_ready;
    assign pop_s    = head_r & out_ready & ~flush;
    assign rd_s     = (mcnt_r != {LW{1'b0}}) & (~head_r | pop_s) & ~flush;

    assign out_valid = head_r;
    assign out_data  = mem_rdata;
    assign level     = level_r;
    assign afull     = afull_r;
    assign mem_we_n  = ~push_s;
    assign mem_waddr = push_s ? wptr_r : waddr_hold_r;
    assign mem_wdata = push_s ? in_data : wdata_hold_r;
    assign mem_re_n  = ~rd_s;
    assign mem_raddr = rd_s ? rptr_r : raddr_hold_r;

    // Next-state computation for pointers, memory count and head stage.
    always_comb begin
        wptr_nxt_s = wptr_r;
        rptr_nxt_s = rptr_r;
        mcnt_nxt_s = mcnt_r;
        head_nxt_s = head_r;
        if (flush) begin
            wptr_nxt_s = {AW{1'b0}};
            rptr_nxt_s = {AW{1'b0}};
            mcnt_nxt_s = {LW{1'b0}};
            head_nxt_s = 1'b0;
        end else begin
            if (push_s) begin
                wptr_nxt_s = ptr_inc(wptr_r);
            end else begin
                wptr_nxt_s = wptr_r;
            end
            if (rd_s) begin
                rptr_nxt_s = ptr_inc(rptr_r);
                head_nxt_s = 1'b1;
            end else if (pop_s) begin
                head_nxt_s = 1'b0;
            end else begin
                head_nxt_s = head_r;
            end
            if (push_s && !rd_s) begin
                mcnt_nxt_s = mcnt_r + LW'(1'b1);
            end else if (!push_s && rd_s) begin
                mcnt_nxt_s = mcnt_r - LW'(1'b1);
            end else begin
                mcnt_nxt_s = mcnt_r;
            end
        end
        level_nxt_s = mcnt_nxt_s + LW'(head_nxt_s);
        afull_nxt_s = (int'(level_nxt_s) >= AF_LVL);
    end

    // Control state plus level/afull registered from the same next values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_r  <= {AW{1'b0}};
            rptr_r  <= {AW{1'b0}};
            mcnt_r  <= {LW{1'b0}};
            head_r  <= 1'b0;
            level_r <= {LW{1'b0}};
            afull_r <= 1'b0;
        end else begin
            wptr_r  <= wptr_nxt_s;
            rptr_r  <= rptr_nxt_s;
            mcnt_r  <= mcnt_nxt_s;
            head_r  <= head_nxt_s;
            level_r <= level_nxt_s;
            afull_r <= afull_nxt_s;
        end
    end

    // Last issued memory address/data, presented while the enable is idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            waddr_hold_r <= {AW{1'b0}};
            wdata_hold_r <= {DW{1'b0}};
            raddr_hold_r <= {AW{1'b0}};
        end else begin
            if (push_s) begin
                waddr_hold_r <= wptr_r;
                wdata_hold_r <= in_data;
            end
            if (rd_s) begin
                raddr_hold_r <= rptr_r;
            end
        end
    end

endmodule

// File: tb/tb_stdcore_rf_fifo_ctl.sv
// Self-checking bench: DEPTH=4 instance against a queue model plus vectors,
// DEPTH=3 instance for streaming with pointer wrap.
module tb_stdcore_rf_fifo_ctl;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    int n_cmp = 0;
    int n_bad = 0;

    logic       a_flush, a_in_valid, a_out_ready, a_in_ready, a_out_valid, a_afull;
    logic [7:0] a_in_data, a_out_data, a_wdata, a_rdata;
    logic [2:0] a_level;
    logic       a_we_n, a_re_n;
    logic [1:0] a_waddr, a_raddr;
    logic [7:0] a_mem [0:3];

    logic       b_flush, b_in_valid, b_out_ready, b_in_ready, b_out_valid, b_afull;
    logic [7:0] b_in_data, b_out_data, b_wdata, b_rdata;
    logic [2:0] b_level;
    logic       b_we_n, b_re_n;
    logic [1:0] b_waddr, b_raddr;
    logic [7:0] b_mem [0:2];

    stdcore_rf_fifo_ctl #(.DW(8), .DEPTH(4), .AW(2), .LW(3), .AF_LVL(4)) u_a (
        .clk(clk), .rst_n(rst_n), .flush(a_flush), .in_valid(a_in_valid), .in_data(a_in_data),
        .in_ready(a_in_ready), .out_valid(a_out_valid), .out_data(a_out_data), .out_ready(a_out_ready),
        .level(a_level), .afull(a_afull), .mem_we_n(a_we_n), .mem_waddr(a_waddr), .mem_wdata(a_wdata),
        .mem_re_n(a_re_n), .mem_raddr(a_raddr), .mem_rdata(a_rdata));

    stdcore_rf_fifo_ctl #(.DW(8), .DEPTH(3), .AW(2), .LW(3), .AF_LVL(2)) u_b (
        .clk(clk), .rst_n(rst_n), .flush(b_flush), .in_valid(b_in_valid), .in_data(b_in_data),
        .in_ready(b_in_ready), .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(b_out_ready),
        .level(b_level), .afull(b_afull), .mem_we_n(b_we_n), .mem_waddr(b_waddr), .mem_wdata(b_wdata),
        .mem_re_n(b_re_n), .mem_raddr(b_raddr), .mem_rdata(b_rdata));

    // External RF memories with one-cycle read latency.
    always @(posedge clk) begin
        if (!a_we_n) a_mem[a_waddr] <= a_wdata;
        if (!a_re_n) a_rdata <= a_mem[a_raddr];
        if (!b_we_n) b_mem[b_waddr] <= b_wdata;
        if (!b_re_n) b_rdata <= b_mem[b_raddr];
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    // Reference model for instance A: unread memory words and the head word.
    logic [7:0] mq[$];
    logic       m_hv;
    logic [7:0] m_hd, last_wd;
    int         wslot, rslot, last_wa, last_ra;

    typedef struct packed {
        logic       iv;
        logic [7:0] d;
        logic       ordy;
        logic       fl;
        logic       e_ir;
        logic       e_ov;
        logic [7:0] e_od;
        logic [2:0] e_lvl;
        logic       e_af;
        logic       e_we_n;
        logic       e_re_n;
        logic [1:0] e_wa;
        logic [1:0] e_ra;
    } vec_t;
    vec_t tv [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_hv = 1'b0; m_hd = 8'h00; last_wd = 8'h00;
        wslot = 0; rslot = 0; last_wa = 0; last_ra = 0;
    endtask

    task automatic check_a();
        int  lv;
        bit  push, pop, rd;
        lv   = mq.size() + int'(m_hv);
        push = a_in_valid && (mq.size() < 4) && !a_flush;
        pop  = m_hv && a_out_ready && !a_flush;
        rd   = (mq.size() > 0) && (!m_hv || pop) && !a_flush;
        chk("a_in_ready", a_in_ready, (mq.size() < 4) && !a_flush);
        chk("a_out_valid", a_out_valid, m_hv);
        if (m_hv) chk("a_out_data", a_out_data, m_hd);
        chk("a_level", a_level, lv);
        chk("a_afull", a_afull, lv >= 4);
        chk("a_we_n", a_we_n, !push);
        chk("a_re_n", a_re_n, !rd);
        if (push) begin
            chk("a_waddr", a_waddr, wslot);
            chk("a_wdata", a_wdata, a_in_data);
        end else begin
            chk("a_waddr_hold", a_waddr, last_wa);
            chk("a_wdata_hold", a_wdata, last_wd);
        end
        if (rd) chk("a_raddr", a_raddr, rslot);
        else    chk("a_raddr_hold", a_raddr, last_ra);
        if (!a_we_n && !a_re_n) chk("a_addr_conflict", a_waddr != a_raddr, 1);
    endtask

    task automatic drive_a(input logic iv, input logic [7:0] d, input logic ordy, input logic fl);
        @(negedge clk);
        a_in_valid = iv; a_in_data = d; a_out_ready = ordy; a_flush = fl;
        #1;
        check_a();
    endtask

    task automatic edge_a();
        bit push, pop, rd;
        @(posedge clk);
        push = a_in_valid && (mq.size() < 4) && !a_flush;
        pop  = m_hv && a_out_ready && !a_flush;
        rd   = (mq.size() > 0) && (!m_hv || pop) && !a_flush;
        if (a_flush) begin
            mq.delete(); m_hv = 1'b0; wslot = 0; rslot = 0;
        end else begin
            if (push) begin
                last_wa = wslot; last_wd = a_in_data; wslot = (wslot + 1) % 4;
            end
            if (rd) begin
                last_ra = rslot; rslot = (rslot + 1) % 4;
                m_hd = mq.pop_front(); m_hv = 1'b1;
            end else if (pop) begin
                m_hv = 1'b0;
            end
            if (push) mq.push_back(a_in_data);
        end
    endtask

    task automatic step_a(input logic iv, input logic [7:0] d, input logic ordy, input logic fl);
        drive_a(iv, d, ordy, fl);
        edge_a();
    endtask

    initial begin
        logic [7:0] got[$];
        int nw, nr, piv, por;

        //         iv    d      or    fl    ir    ov    od     lvl   af    we_n  re_n  wa     ra
        tv[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0};
        tv[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0};
        tv[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 3'd1, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0};
        tv[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5, 3'd1, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0};
        tv[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0};
        tv[5]  = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0};
        tv[6]  = '{1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd1, 1'b0, 1'b0, 1'b0, 2'd2, 2'd1};
        tv[7]  = '{1'b1, 8'h03, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 3'd2, 1'b0, 1'b0, 1'b1, 2'd3, 2'd0};
        tv[8]  = '{1'b1, 8'h04, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 3'd3, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0};
        tv[9]  = '{1'b1, 8'h05, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 3'd4, 1'b1, 1'b0, 1'b1, 2'd1, 2'd0};
        tv[10] = '{1'b1, 8'h06, 1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 3'd5, 1'b1, 1'b1, 1'b1, 2'd0, 2'd0};
        tv[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h01, 3'd5, 1'b1, 1'b1, 1'b0, 2'd0, 2'd2};
        tv[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h02, 3'd4, 1'b1, 1'b1, 1'b0, 2'd0, 2'd3};
        tv[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h03, 3'd3, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0};
        tv[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h04, 3'd2, 1'b0, 1'b1, 1'b0, 2'd0, 2'd1};
        tv[15] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h05, 3'd1, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0};
        tv[16] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0};

        rst_n = 1'b0;
        a_flush = 1'b0; a_in_valid = 1'b0; a_in_data = 8'h00; a_out_ready = 1'b0;
        b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = 8'h00; b_out_ready = 1'b0;
        model_clear();
        #1;
        chk("rst_in_ready", a_in_ready, 1);
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_level", a_level, 0);
        chk("rst_afull", a_afull, 0);
        chk("rst_we_n", a_we_n, 1);
        chk("rst_re_n", a_re_n, 1);
        chk("rst_waddr", a_waddr, 0);
        chk("rst_raddr", a_raddr, 0);
        chk("rst_b_level", b_level, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // First-word latency, fill to capacity, drain in order.
        for (int i = 0; i < 17; i++) begin
            drive_a(tv[i].iv, tv[i].d, tv[i].ordy, tv[i].fl);
            chk($sformatf("tv%0d_in_ready", i), a_in_ready, tv[i].e_ir);
            chk($sformatf("tv%0d_out_valid", i), a_out_valid, tv[i].e_ov);
            if (tv[i].e_ov) chk($sformatf("tv%0d_out_data", i), a_out_data, tv[i].e_od);
            chk($sformatf("tv%0d_level", i), a_level, tv[i].e_lvl);
            chk($sformatf("tv%0d_afull", i), a_afull, tv[i].e_af);
            chk($sformatf("tv%0d_we_n", i), a_we_n, tv[i].e_we_n);
            chk($sformatf("tv%0d_re_n", i), a_re_n, tv[i].e_re_n);
            if (!tv[i].e_we_n) chk($sformatf("tv%0d_waddr", i), a_waddr, tv[i].e_wa);
            if (!tv[i].e_re_n) chk($sformatf("tv%0d_raddr", i), a_raddr, tv[i].e_ra);
            edge_a();
        end

        // Backpressure stall while pushing.
        step_a(1'b1, 8'h70, 1'b0, 1'b0);
        step_a(1'b0, 8'h00, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            drive_a(1'b1, 8'(8'h71 + k), 1'b0, 1'b0);
            chk("stall_out_valid", a_out_valid, 1);
            chk("stall_out_data", a_out_data, 8'h70);
            chk("stall_re_n", a_re_n, 1);
            edge_a();
        end

        // Flush with simultaneous push and pop at level 3.
        step_a(1'b0, 8'h00, 1'b0, 1'b1);
        step_a(1'b1, 8'h31, 1'b0, 1'b0);
        step_a(1'b1, 8'h32, 1'b0, 1'b0);
        step_a(1'b1, 8'h33, 1'b0, 1'b0);
        drive_a(1'b0, 8'h00, 1'b0, 1'b0);
        chk("flush_pre_level", a_level, 3);
        edge_a();
        drive_a(1'b1, 8'h99, 1'b1, 1'b1);
        chk("flush_we_n", a_we_n, 1);
        chk("flush_re_n", a_re_n, 1);
        chk("flush_in_ready", a_in_ready, 0);
        edge_a();
        drive_a(1'b0, 8'h00, 1'b0, 1'b0);
        chk("flush_level", a_level, 0);
        chk("flush_out_valid", a_out_valid, 0);
        edge_a();
        step_a(1'b0, 8'h00, 1'b0, 1'b0);
        drive_a(1'b0, 8'h00, 1'b0, 1'b0);
        chk("flush_not_stored", a_out_valid, 0);
        edge_a();

        // Asynchronous reset between edges at level 4.
        step_a(1'b1, 8'h41, 1'b0, 1'b0);
        step_a(1'b1, 8'h42, 1'b0, 1'b0);
        step_a(1'b1, 8'h43, 1'b0, 1'b0);
        step_a(1'b1, 8'h44, 1'b0, 1'b0);
        drive_a(1'b0, 8'h00, 1'b0, 1'b0);
        chk("arst_pre_level", a_level, 4);
        edge_a();
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", a_out_valid, 0);
        chk("arst_level", a_level, 0);
        chk("arst_we_n", a_we_n, 1);
        chk("arst_re_n", a_re_n, 1);
        chk("arst_raddr", a_raddr, 0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        step_a(1'b1, 8'h11, 1'b0, 1'b0);
        step_a(1'b0, 8'h00, 1'b0, 1'b0);
        drive_a(1'b0, 8'h00, 1'b0, 1'b0);
        chk("arst_post_valid", a_out_valid, 1);
        chk("arst_post_data", a_out_data, 8'h11);
        edge_a();

        // Randomized traffic with shifting push/pop rates against the model.
        for (int i = 0; i < 600; i++) begin
            piv = (((i / 100) % 3) == 0) ? 85 : ((((i / 100) % 3) == 1) ? 30 : 60);
            por = (((i / 100) % 3) == 0) ? 30 : ((((i / 100) % 3) == 1) ? 85 : 60);
            step_a($urandom_range(0, 99) < piv, 8'($urandom), $urandom_range(0, 99) < por,
                   $urandom_range(0, 49) == 0);
        end

        // Streaming with wrap on the DEPTH=3 instance.
        nw = 0; nr = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            b_in_valid = (i < 20); b_in_data = 8'(i); b_out_ready = 1'b1;
            #1;
            if (i < 20) chk("b_in_ready", b_in_ready, 1);
            if (b_out_valid) got.push_back(b_out_data);
            if (!b_we_n) begin chk("b_waddr", b_waddr, nw % 3); nw++; end
            if (!b_re_n) begin chk("b_raddr", b_raddr, nr % 3); nr++; end
            if (!b_we_n && !b_re_n) chk("b_addr_conflict", b_waddr != b_raddr, 1);
        end
        chk("b_writes", nw, 20);
        chk("b_reads", nr, 20);
        chk("b_count", got.size(), 20);
        for (int k = 0; k < 20; k++) begin
            if (k < got.size()) chk($sformatf("b_order%0d", k), got[k], k);
        end
        chk("b_drained_level", b_level, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
